// File: rtl/f2h_tester_pkg.sv
`default_nettype none
// ============================================================================
// Module   : f2h_tester_pkg
// Purpose  : Shared definitions for the F2H access engine: FSM state
//            encoding, latency counter width and byte-enable mask helper.
// Revision : 1.0 - initial release
// ============================================================================
package f2h_tester_pkg;

  // Width of the read round-trip latency counter and its reported value.
  localparam int LAT_W = 32;

  // Widest byte-enable mask the helper can produce (1024-bit data path).
  localparam int BE_MAX = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } f2h_state_e;

  // Plain-vector views of the state encoding for the FSM register.
  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_WR_REQ  = WR_REQ;
  localparam logic [1:0] ST_RD_REQ  = RD_REQ;
  localparam logic [1:0] ST_RD_WAIT = RD_WAIT;

  // Ones on every byte belonging to 'lane', where each lane is
  // 'lane_bytes' bytes wide. Callers truncate to their own bus width.
  function automatic logic [BE_MAX-1:0] lane_byteenable(input int unsigned lane,
                                                        input int unsigned lane_bytes);
    logic [BE_MAX-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < BE_MAX; i++) begin
      mask[i] = ((i / lane_bytes) == lane);
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/f2h_lane_mux.sv
`default_nettype none
// ============================================================================
// Module   : f2h_lane_mux
// Purpose  : Combinational lane handling between the narrow CSR word and the
//            wide F2H data path.
// Ports    : be_lane      - lane whose bytes are enabled
//            rd_lane      - lane selected out of the returned read word
//            avm_readdata - wide read word from the bridge
//            write_data   - narrow write payload
//            lane_rdata   - selected narrow read word
//            wdata_rep    - write payload replicated across all lanes
//            byteenable   - one-hot-lane byte enable mask
// Revision : 1.0 - initial release
// ============================================================================
module f2h_lane_mux
  import f2h_tester_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int AVM_DATA_WIDTH = 128,
  parameter int LANE_W         = 2
) (
  input  logic [LANE_W-1:0]           be_lane,
  input  logic [LANE_W-1:0]           rd_lane,
  input  logic [AVM_DATA_WIDTH-1:0]   avm_readdata,
  input  logic [DATA_WIDTH-1:0]       write_data,
  output logic [DATA_WIDTH-1:0]       lane_rdata,
  output logic [AVM_DATA_WIDTH-1:0]   wdata_rep,
  output logic [AVM_DATA_WIDTH/8-1:0] byteenable
);

  localparam int LANES = AVM_DATA_WIDTH / DATA_WIDTH;

  assign lane_rdata = avm_readdata[32'(rd_lane) * DATA_WIDTH +: DATA_WIDTH];
  assign wdata_rep  = {LANES{write_data}};
  assign byteenable = (AVM_DATA_WIDTH/8)'(lane_byteenable(32'(be_lane), DATA_WIDTH / 8));

endmodule
`default_nettype wire

// File: rtl/f2h_access_fsm.sv
`default_nettype none
// ============================================================================
// Module   : f2h_access_fsm
// Purpose  : Executes single-word host-memory reads/writes through the F2H
//            bridge as an Avalon-MM master, one transaction at a time, and
//            reports read data plus measured read round-trip latency.
// Ports    : clk, rstn (async active-low)
//            CSR side : read, write, address, write_data -> read_data,
//                       read_data_valid, read_latency, busy, timeout,
//                       req_dropped
//            F2H side : avm_address/read/write/writedata/byteenable out,
//                       avm_waitrequest/readdata/readdatavalid in
// Revision : 1.0 - initial release
// ============================================================================
module f2h_access_fsm
  import f2h_tester_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int AVM_ADDR_WIDTH = 32,
  parameter int AVM_DATA_WIDTH = 128,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        read,
  input  logic                        write,
  input  logic [DATA_WIDTH-1:0]       address,
  input  logic [DATA_WIDTH-1:0]       write_data,
  output logic [DATA_WIDTH-1:0]       read_data,
  output logic                        read_data_valid,
  output logic [LAT_W-1:0]            read_latency,
  output logic                        busy,
  output logic                        timeout,
  output logic                        req_dropped,
  output logic [AVM_ADDR_WIDTH-1:0]   avm_address,
  output logic                        avm_read,
  output logic                        avm_write,
  output logic [AVM_DATA_WIDTH-1:0]   avm_writedata,
  output logic [AVM_DATA_WIDTH/8-1:0] avm_byteenable,
  input  logic                        avm_waitrequest,
  input  logic [AVM_DATA_WIDTH-1:0]   avm_readdata,
  input  logic                        avm_readdatavalid
);

  localparam int DB     = DATA_WIDTH / 8;
  localparam int AB     = AVM_DATA_WIDTH / 8;
  localparam int DB_LOG = $clog2(DB);
  localparam int LANES  = AVM_DATA_WIDTH / DATA_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [1:0]                  r_state;
  logic [LANE_W-1:0]           r_lane;
  logic                        r_pending_rd;
  logic [LAT_W-1:0]            r_lat_cnt;
  logic [DATA_WIDTH-1:0]       r_read_data;
  logic [LAT_W-1:0]            r_read_latency;
  logic                        r_rdv;
  logic                        r_timeout;
  logic                        r_drop;
  logic [AVM_ADDR_WIDTH-1:0]   r_avm_address;
  logic                        r_avm_read;
  logic                        r_avm_write;
  logic [AVM_DATA_WIDTH-1:0]   r_avm_writedata;
  logic [AVM_DATA_WIDTH/8-1:0] r_avm_be;

  logic [LANE_W-1:0]           w_cmd_lane;
  logic [AVM_ADDR_WIDTH-1:0]   w_cmd_addr;
  logic [DATA_WIDTH-1:0]       w_lane_rdata;
  logic [AVM_DATA_WIDTH-1:0]   w_wdata_rep;
  logic [AVM_DATA_WIDTH/8-1:0] w_be;
  logic [LAT_W-1:0]            w_lat_next;
  logic                        w_rd_done;
  logic                        w_rd_abort;

  // Lane index sits between the CSR-word and bridge-word alignment bits;
  // masking keeps it at zero when both widths are equal.
  assign w_cmd_lane = LANE_W'((address >> DB_LOG) & DATA_WIDTH'(LANES - 1));
  assign w_cmd_addr = AVM_ADDR_WIDTH'(address & ~DATA_WIDTH'(AB - 1));

  assign w_lat_next = (r_lat_cnt == '1) ? r_lat_cnt : r_lat_cnt + 1'b1;

  // A response counts from the accept cycle of the request onward.
  assign w_rd_done  = avm_readdatavalid &&
                      ((r_state == ST_RD_WAIT) ||
                       (r_state == ST_RD_REQ && !avm_waitrequest));
  // A valid arriving in the very cycle the limit is hit still wins.
  assign w_rd_abort = (r_state == ST_RD_WAIT) && !avm_readdatavalid &&
                      (r_lat_cnt >= LAT_W'(TIMEOUT_CYCLES));

  f2h_lane_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .AVM_DATA_WIDTH (AVM_DATA_WIDTH),
    .LANE_W         (LANE_W)
  ) u_lane_mux (
    .be_lane      (w_cmd_lane),
    .rd_lane      (r_lane),
    .avm_readdata (avm_readdata),
    .write_data   (write_data),
    .lane_rdata   (w_lane_rdata),
    .wdata_rep    (w_wdata_rep),
    .byteenable   (w_be)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= ST_IDLE;
      r_lane          <= '0;
      r_pending_rd    <= 1'b0;
      r_lat_cnt       <= '0;
      r_read_data     <= '0;
      r_read_latency  <= '0;
      r_rdv           <= 1'b0;
      r_timeout       <= 1'b0;
      r_drop          <= 1'b0;
      r_avm_address   <= '0;
      r_avm_read      <= 1'b0;
      r_avm_write     <= 1'b0;
      r_avm_writedata <= '0;
      r_avm_be        <= '0;
    end else begin
      r_rdv  <= 1'b0;
      r_drop <= (r_state != ST_IDLE) && (read || write);

      case (r_state)
        ST_IDLE: begin
          if (read || write) begin
            r_lane          <= w_cmd_lane;
            r_avm_address   <= w_cmd_addr;
            r_avm_writedata <= w_wdata_rep;
            r_avm_be        <= w_be;
            r_timeout       <= 1'b0;
            if (write) begin
              // Simultaneous read is remembered and replayed after the write.
              r_state      <= ST_WR_REQ;
              r_avm_write  <= 1'b1;
              r_pending_rd <= read;
            end else begin
              r_state    <= ST_RD_REQ;
              r_avm_read <= 1'b1;
              r_lat_cnt  <= LAT_W'(1);
            end
          end
        end

        ST_WR_REQ: begin
          if (!avm_waitrequest) begin
            r_avm_write <= 1'b0;
            if (r_pending_rd) begin
              r_pending_rd <= 1'b0;
              r_state      <= ST_RD_REQ;
              r_avm_read   <= 1'b1;
              r_lat_cnt    <= LAT_W'(1);
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        ST_RD_REQ: begin
          r_lat_cnt <= w_lat_next;
          if (!avm_waitrequest) begin
            r_avm_read <= 1'b0;
            r_state    <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          r_lat_cnt <= w_lat_next;
        end

        default: r_state <= ST_IDLE;
      endcase

      // Completion overrides the per-state next-state choice above.
      if (w_rd_done) begin
        r_read_data    <= w_lane_rdata;
        r_read_latency <= r_lat_cnt;
        r_rdv          <= 1'b1;
        r_state        <= ST_IDLE;
      end else if (w_rd_abort) begin
        r_read_data    <= '1;
        r_read_latency <= LAT_W'(TIMEOUT_CYCLES);
        r_rdv          <= 1'b1;
        r_timeout      <= 1'b1;
        r_state        <= ST_IDLE;
      end
    end
  end

  assign read_data       = r_read_data;
  assign read_data_valid = r_rdv;
  assign read_latency    = r_read_latency;
  assign busy            = (r_state != ST_IDLE);
  assign timeout         = r_timeout;
  assign req_dropped     = r_drop;
  assign avm_address     = r_avm_address;
  assign avm_read        = r_avm_read;
  assign avm_write       = r_avm_write;
  assign avm_writedata   = r_avm_writedata;
  assign avm_byteenable  = r_avm_be;

endmodule
`default_nettype wire

// File: doc/f2h_access_fsm.md
Name: f2h_access_fsm

Overview:
- Executes single-word accesses to host memory through the FPGA-to-HPS (F2H) bridge. It takes one-cycle read/write command pulses and address/data from the F2H tester CSR block.
- Acts as an Avalon-MM master toward the F2H bridge.
- Returns read data with a one-cycle valid strobe and a measured read round-trip latency to the CSR block.
- Sits between the tester CSR slave and the F2H interconnect port.

Parameters:
- DATA_WIDTH, 32, CSR-side address/data width.
- AVM_ADDR_WIDTH, 32, F2H master byte-address width.
- AVM_DATA_WIDTH, 128, F2H data path width; power of two, ≥ DATA_WIDTH.
- TIMEOUT_CYCLES, 65535, maximum cycles in read wait before abort; ≥ 2.

Ports:
- clk  in  1  single clock
- rstn  in  1  asynchronous active-low reset
- read  in  1  read command pulse from CSR
- write  in  1  write command pulse from CSR
- address  in  DATA_WIDTH  byte address, DATA_WIDTH-aligned
- write_data  in  DATA_WIDTH  write payload
- read_data  out  DATA_WIDTH  selected lane of returned read word
- read_data_valid  out  1  one-cycle strobe, read completed or aborted
- read_latency  out  32  cycles of last read, held until next read completes
- busy  out  1  FSM not IDLE
- timeout  out  1  sticky; set on read abort, cleared by next accepted command
- req_dropped  out  1  one-cycle pulse when a command is ignored
- avm_address  out  AVM_ADDR_WIDTH  AVM_DATA_WIDTH-aligned byte address
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_writedata  out  AVM_DATA_WIDTH  write_data replicated to all lanes
- avm_byteenable  out  AVM_DATA_WIDTH/8  one-hot lane enable
- avm_waitrequest  in  1  Avalon waitrequest
- avm_readdata  in  AVM_DATA_WIDTH  Avalon read data
- avm_readdatavalid  in  1  Avalon read data valid

Behaviour:
- **Reset.** On rstn low, all outputs go to 0 immediately and the FSM goes to IDLE. Registers are cleared: lat_cnt, read_latency, read_data, lane, pending_rd, timeout.
- **States:** IDLE, WR_REQ, RD_REQ, RD_WAIT.
- **Lane and address.** lane = address[log2(AVM_DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)], captured on command acceptance. avm_address = address with the low log2(AVM_DATA_WIDTH/8) bits zeroed; zero-extend or truncate to AVM_ADDR_WIDTH. avm_byteenable has ones only on bytes of the selected lane. All master outputs are registered.
- **IDLE, write:** write=1 → latch address/data/lane, go to WR_REQ; avm_write=1 next cycle.
- **IDLE, read:** read=1 (write=0) → latch, go to RD_REQ; avm_read=1 next cycle.
- **IDLE, both:** read=1 and write=1 in the same cycle → execute the write first and set pending_rd. After the write completes, the FSM goes directly to RD_REQ with the same address and lane.
- **Command acceptance** clears timeout.
- **WR_REQ:** hold avm_write and signals while avm_waitrequest=1. First cycle with avm_waitrequest=0 → deassert, go to IDLE, or to RD_REQ if pending_rd (then clear pending_rd). No completion strobe for writes.
- **RD_REQ:**
  - lat_cnt loads 1 in the first RD_REQ cycle and increments each cycle, saturating at 32'hFFFF_FFFF.
  - Hold avm_read while avm_waitrequest=1.
  - Accept cycle → go to RD_WAIT.
  - avm_readdatavalid in the accept cycle or later counts as the response.
- **RD_WAIT:**
  - On avm_readdatavalid: read_data = avm_readdata lane; read_latency = lat_cnt, inclusive of the valid cycle. read_data_valid=1 for one cycle (registered, the cycle after the valid), then go to IDLE.
  - If lat_cnt reaches TIMEOUT_CYCLES first: read_data = all ones, read_latency = TIMEOUT_CYCLES, read_data_valid pulses, timeout=1, go to IDLE.
- **Stray responses.** avm_readdatavalid seen outside RD_REQ/RD_WAIT (a late response after an abort) is discarded silently.
- **Busy and drops.** busy = (state != IDLE). A read or write pulse while busy is ignored and req_dropped pulses the next cycle. pending_rd is not affected.
- **No overlap.** Read data never overlaps a following request: only one outstanding transaction.
- **Reset mid-transaction:** abandon immediately; no completion strobe. A later avm_readdatavalid is discarded by the IDLE rule.

Decomposition:
- Package f2h_tester_pkg holds:
  - state enum (IDLE, WR_REQ, RD_REQ, RD_WAIT);
  - LAT_W=32;
  - a function computing the byteenable mask from lane.
- One sub-module is natural: f2h_lane_mux. It is combinational: lane select of avm_readdata, write-data replication, byteenable generation. The FSM and counters stay in the top.

Test Plan:
- Write, address 0x0000_0014, data 0xA5A5_1234, waitrequest held 3 cycles → avm_write high 4 cycles. avm_address 0x10, byteenable 16'h00F0, lane 1 writedata = 0xA5A5_1234; no read_data_valid.
- Read, address 0x0000_0008, waitrequest 0, readdatavalid 5 cycles after accept with readdata lane 2 = 0xCAFE_F00D → read_data 0xCAFE_F00D, read_data_valid one cycle, read_latency 6.
- Read and write pulsed together at address 0x0 → write completes first, then read issued to the same address. Exactly one read_data_valid is seen.
- Read with no readdatavalid and TIMEOUT_CYCLES=16 → read_data 0xFFFF_FFFF, read_latency 16, timeout=1. A stray readdatavalid 10 cycles later is ignored; the next write command clears timeout.
- Write pulse while in RD_WAIT → req_dropped one-cycle pulse, no avm_write, read completes normally.
- rstn asserted in RD_WAIT → all outputs 0 asynchronously. A post-reset readdatavalid produces no read_data_valid; the next read behaves normally.
